// File: rtl/keypad_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keypad_scheduler: ten-key BCD keypad scanner with one shared debouncer.   |
// | Optional auto-repeat while a key is held: define KEY_REPEAT_EN.           |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module keypad_scheduler #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] keys,
  output logic [3:0] code,
  output logic       valid,
  output logic       busy,
  output logic       collision
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_SETTLE  = 2'd1;
  localparam logic [1:0] c_HELD    = 2'd2;
  localparam logic [1:0] c_RELEASE = 2'd3;
  localparam logic [3:0] c_DEB     = 4'(DEBOUNCE_CYCLES);

  logic [1:0]  r_state;
  logic [3:0]  r_owner;
  logic [3:0]  r_cnt;
  logic [3:0]  r_code;
  logic        r_valid;
  logic        r_collision;

  logic [3:0]  w_low_idx;
  logic        w_multi;
  logic        w_owner_hi;
  logic [3:0]  w_cnt_inc;
  logic [15:0] w_keys_ext;

  // Lowest-index key wins ownership of the debouncer.
  always_comb begin
    w_low_idx = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (keys[i]) w_low_idx = 4'(i);
    end
  end

  assign w_multi    = |(keys & (keys - 10'd1));
  assign w_keys_ext = {6'd0, keys};
  assign w_owner_hi = w_keys_ext[r_owner];
  assign w_cnt_inc  = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;

`ifdef KEY_REPEAT_EN
  localparam logic [7:0] c_REP = 8'(REPEAT_CYCLES);
  logic [7:0] r_rep;
  logic [7:0] w_rep_inc;
  assign w_rep_inc = (r_rep == 8'hFF) ? r_rep : r_rep + 8'd1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_IDLE;
      r_owner     <= 4'd0;
      r_cnt       <= 4'd0;
      r_code      <= 4'd0;
      r_valid     <= 1'b0;
      r_collision <= 1'b0;
`ifdef KEY_REPEAT_EN
      r_rep       <= 8'd0;
`endif
    end else begin
      r_valid     <= 1'b0;
      r_collision <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (|keys) begin
            r_owner     <= w_low_idx;
            r_cnt       <= 4'd1;
            r_collision <= w_multi;
            r_state     <= c_SETTLE;
          end
        end
        c_SETTLE: begin
          if (w_owner_hi) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == c_DEB) begin
              r_state <= c_HELD;
              r_valid <= 1'b1;
              r_code  <= r_owner;
`ifdef KEY_REPEAT_EN
              r_rep   <= 8'd0;
`endif
            end
          end else begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
          end
        end
        c_HELD: begin
          if (!w_owner_hi) begin
            r_state <= c_RELEASE;
            r_cnt   <= 4'd0;
          end
`ifdef KEY_REPEAT_EN
          else if (w_rep_inc == c_REP) begin
            r_valid <= 1'b1;
            r_rep   <= 8'd0;
          end else begin
            r_rep <= w_rep_inc;
          end
`endif
        end
        c_RELEASE: begin
          // Any key activity restarts the quiet-time count.
          if (|keys) begin
            r_cnt <= 4'd0;
          end else if (w_cnt_inc == c_DEB) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign code      = r_code;
  assign valid     = r_valid;
  assign busy      = (r_state != c_IDLE);
  assign collision = r_collision;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_keypad_scheduler: directed self-checking bench for keypad_scheduler.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_keypad_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] keys = 10'd0;
  logic [3:0] code;
  logic       valid;
  logic       busy;
  logic       collision;

  int n_vec = 0;
  int n_err = 0;
  int n_valid = 0;
  int n_tick = 0;
  int first_rep = -1;

  keypad_scheduler #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .keys(keys),
    .code(code), .valid(valid), .busy(busy), .collision(collision)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    n_tick++;
    if (valid === 1'b1) n_valid++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int base;
    ticks(2);
    chk("rst_code", int'(code), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_coll", int'(collision), 0);
    reset = 1'b0;

    // Key 3 held 10 cycles.
    keys = 10'h008;
    base = n_valid;
    tick();
    chk("k3_busy1", int'(busy), 1);
    chk("k3_coll1", int'(collision), 0);
    ticks(2);
    chk("k3_valid3", int'(valid), 0);
    tick();
    chk("k3_valid4", int'(valid), 1);
    chk("k3_code4", int'(code), 3);
    ticks(6);
    chk("k3_nvalid", n_valid - base, 1);
    keys = 10'h000;
    ticks(4);
    chk("k3_rel_busy", int'(busy), 1);
    tick();
    chk("k3_rel_idle", int'(busy), 0);

    // Glitch on key 5 rejected.
    keys = 10'h020;
    base = n_valid;
    ticks(2);
    keys = 10'h000;
    tick();
    chk("gl_busy", int'(busy), 0);
    chk("gl_nvalid", n_valid - base, 0);
    chk("gl_code", int'(code), 3);

    // Keys 5 and 7 together.
    keys = 10'h0A0;
    tick();
    chk("co_coll1", int'(collision), 1);
    tick();
    chk("co_coll2", int'(collision), 0);
    tick();
    chk("co_valid3", int'(valid), 0);
    tick();
    chk("co_valid4", int'(valid), 1);
    chk("co_code", int'(code), 5);
    keys = 10'h000;
    ticks(5);
    chk("co_idle", int'(busy), 0);

    // Key 2 with a bounce during release.
    keys = 10'h004;
    ticks(4);
    chk("bo_valid", int'(valid), 1);
    chk("bo_code", int'(code), 2);
    base = n_valid;
    keys = 10'h000;
    ticks(2);
    keys = 10'h004;
    tick();
    keys = 10'h000;
    ticks(3);
    chk("bo_busy3", int'(busy), 1);
    tick();
    chk("bo_idle4", int'(busy), 0);
    chk("bo_nvalid", n_valid - base, 0);

    // Reset one cycle before acceptance, key stays held.
    keys = 10'h010;
    base = n_valid;
    ticks(3);
    reset = 1'b1;
    tick();
    chk("rs_valid", int'(valid), 0);
    chk("rs_code", int'(code), 0);
    chk("rs_busy", int'(busy), 0);
    chk("rs_nvalid", n_valid - base, 0);
    reset = 1'b0;
    tick();
    chk("rs_rebusy", int'(busy), 1);
    ticks(2);
    chk("rs_revalid3", int'(valid), 0);
    tick();
    chk("rs_revalid4", int'(valid), 1);
    chk("rs_recode", int'(code), 4);
    keys = 10'h000;
    ticks(5);
    chk("rs_idle", int'(busy), 0);

    // Key 9 held 30 cycles after acceptance.
    keys = 10'h200;
    ticks(4);
    chk("rp_valid", int'(valid), 1);
    chk("rp_code", int'(code), 9);
    base = n_valid;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (valid === 1'b1 && first_rep < 0) first_rep = i;
    end
    chk("rp_code_hold", int'(code), 9);
`ifdef KEY_REPEAT_EN
    chk("rp_nvalid", n_valid - base, 3);
    chk("rp_first", first_rep, 8);
`else
    chk("rp_nvalid", n_valid - base, 0);
    chk("rp_first", first_rep, -1);
`endif
    keys = 10'h000;
    ticks(5);
    chk("rp_idle", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
